// File: rtl/method_call_driver_if.sv
// Handshake bundle between method_call_driver and its environment:
// the start/status side plus the downstream method req/busy/return.
interface method_call_driver_if #(
    parameter int unsigned RET_WIDTH = 32
);
    logic                 start;
    logic                 method_req;
    logic                 method_busy;
    logic [RET_WIDTH-1:0] method_return;
    logic                 done;
    logic                 pass;
    logic                 fail;
    logic                 timed_out;
    logic [RET_WIDTH-1:0] result;
    logic [31:0]          cycles;

    modport master (
        input  start, method_busy, method_return,
        output method_req, done, pass, fail, timed_out, result, cycles
    );

    modport slave (
        output start, method_busy, method_return,
        input  method_req, done, pass, fail, timed_out, result, cycles
    );
endinterface

// File: rtl/method_call_driver.sv
// Drives one call of a req/busy method after a start delay, captures its
// return, and reports pass/fail/timeout plus the call latency.
module method_call_driver #(
    parameter int unsigned          RET_WIDTH   = 32,
    parameter int unsigned          START_DELAY = 100,
    parameter int unsigned          TIMEOUT     = 10000,
    parameter logic [RET_WIDTH-1:0] EXPECTED    = RET_WIDTH'(1)
) (
    input logic                  clk,
    input logic                  reset,
    method_call_driver_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [31:0] DLY_LAST  = (START_DELAY == 0) ? '0 : 32'(START_DELAY - 1);
    localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

    state_t               state_q, state_d;
    logic [31:0]          dly_q, dly_d;
    logic [31:0]          cyc_q, cyc_d;
    logic                 req_q, req_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 fail_q, fail_d;
    logic                 to_q, to_d;
    logic [RET_WIDTH-1:0] result_q, result_d;

    logic [31:0] cyc_inc;
    logic        timeout_hit;

    // Latency counter saturates instead of wrapping
    assign cyc_inc     = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;
    assign timeout_hit = (cyc_inc >= TIMEOUT_W);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            dly_q    <= '0;
            cyc_q    <= '0;
            req_q    <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            to_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            dly_q    <= dly_d;
            cyc_q    <= cyc_d;
            req_q    <= req_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            to_q     <= to_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dly_d    = dly_q;
        cyc_d    = cyc_q;
        req_d    = req_q;
        done_d   = done_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        to_d     = to_q;
        result_d = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    done_d = 1'b0;
                    pass_d = 1'b0;
                    fail_d = 1'b0;
                    to_d   = 1'b0;
                    dly_d  = '0;
                    if (START_DELAY == 0) begin
                        state_d = S_REQ;
                        req_d   = 1'b1;
                        cyc_d   = '0;
                    end else begin
                        state_d = S_DELAY;
                    end
                end
            end

            S_DELAY: begin
                if (dly_q == DLY_LAST) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    cyc_d   = '0;
                end else begin
                    dly_d = dly_q + 32'd1;
                end
            end

            S_REQ: begin
                cyc_d = cyc_inc;
                if (timeout_hit) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    to_d    = 1'b1;
                    fail_d  = 1'b1;
                    pass_d  = 1'b0;
                end else if (bus.method_busy) begin
                    state_d = S_WAIT;
                    req_d   = 1'b0;
                end
            end

            S_WAIT: begin
                cyc_d = cyc_inc;
                // Completion is checked first so it wins over a same-edge timeout
                if (!bus.method_busy) begin
                    state_d  = S_DONE;
                    result_d = bus.method_return;
                    done_d   = 1'b1;
                    pass_d   = (bus.method_return == EXPECTED);
                    fail_d   = (bus.method_return != EXPECTED);
                    to_d     = 1'b0;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    to_d    = 1'b1;
                    fail_d  = 1'b1;
                    pass_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    assign bus.method_req = req_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.fail       = fail_q;
    assign bus.timed_out  = to_q;
    assign bus.result     = result_q;
    assign bus.cycles     = cyc_q;

endmodule

// File: doc/method_call_driver.md
METHOD_CALL_DRIVER -- requirements
Module: method_call_driver

Interface
REQ-001 Parameter RET_WIDTH, default 32: width of method return value.
REQ-002 Parameter START_DELAY, default 100: idle cycles between start acceptance and first request.
REQ-003 Parameter TIMEOUT, default 10000: maximum cycles from request assertion to completion.
REQ-004 Parameter EXPECTED, default 1 (RET_WIDTH bits): value the captured return is compared against.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse requesting a method call; ignored unless idle or done.
REQ-008 method_req  output  1  request to downstream method (req port of called method).
REQ-009 method_busy  input  1  busy from called method.
REQ-010 method_return  input  RET_WIDTH  return value from called method.
REQ-011 done  output  1  level; call finished (completion or timeout).
REQ-012 pass  output  1  level; valid with done, result equals EXPECTED and no timeout.
REQ-013 fail  output  1  level; valid with done, mismatch or timeout.
REQ-014 timed_out  output  1  level; valid with done, completion never observed.
REQ-015 result  output  RET_WIDTH  captured method_return.
REQ-016 cycles  output  32  cycles from method_req rise to completion, saturating at 32'hFFFFFFFF.

Function
REQ-017 States SHALL be IDLE, DELAY, REQ, WAIT, DONE; single-hot encoding not required.
REQ-018 IDLE: start=1 -> DELAY, delay counter cleared to 0; done/pass/fail/timed_out cleared same edge.
REQ-019 DELAY: counter increments per cycle; when counter = START_DELAY-1 -> REQ; START_DELAY=0 -> REQ directly from IDLE.
REQ-020 REQ: method_req=1 (registered, asserted first cycle in REQ); stays until method_busy sampled 1 -> WAIT with method_req deasserted that edge.
REQ-021 WAIT: method_req=0; method_busy sampled 0 -> capture method_return into result, -> DONE.
REQ-022 Busy rising and falling within REQ (never seen high) SHALL not complete; only busy=1 then busy=0 counts.
REQ-023 cycles counter SHALL clear on REQ entry and increment every cycle in REQ and WAIT; frozen in DONE.
REQ-024 cycles reaching TIMEOUT in REQ or WAIT -> DONE with timed_out=1, fail=1, method_req=0, result unchanged.
REQ-025 Completion and timeout on the same edge: completion wins, timed_out=0.
REQ-026 DONE: done=1; pass = (result==EXPECTED) && !timed_out; fail = !pass; pass and fail never both 1.
REQ-027 DONE: start=1 -> DELAY (restart), flags cleared; start in DELAY/REQ/WAIT ignored.
REQ-028 Comparison SHALL be full RET_WIDTH unsigned equality; no sign extension.
REQ-029 All outputs SHALL be registered; no combinational path input -> output.

Reset
REQ-030 reset=1 SHALL asynchronously force IDLE, method_req=0, done=0, pass=0, fail=0, timed_out=0, result=0, cycles=0, delay counter=0.
REQ-031 Reset asserted mid-call (REQ/WAIT) SHALL drop method_req immediately; no completion reported after release.
REQ-032 After reset release, block SHALL remain IDLE until a start pulse.

Verification
REQ-033 START_DELAY=4, start pulse; model raises busy 1 cycle after req, drops 5 cycles later with return=1 -> req high 4 cycles after start, done=1, pass=1, result=1, cycles=7.
REQ-034 Same, return=32'h5 -> done=1, fail=1, pass=0, result=32'h5.
REQ-035 TIMEOUT=20, busy never rises -> after 20 cycles of req: done=1, timed_out=1, fail=1, method_req=0.
REQ-036 busy rises, drops on exactly cycle TIMEOUT -> pass=1, timed_out=0 (completion wins).
REQ-037 reset pulsed while in WAIT -> method_req=0, all flags 0, state IDLE; later start runs a full clean call with pass=1.
REQ-038 Second start while DONE -> flags cleared, second call completes independently; start pulses during WAIT ignored.
